uart_rx_fsm: RTL



---
 rtl/uart_rx_fsm.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//
// UART receiver. It deserialises the asynchronous rx line into a
// FRAMEWIDTH-bit word. The frame format matches the team's UART transmitter:
//     start (0), FRAMEWIDTH data bits LSB first, even parity bit, stop (1).
//
// Each received word is reported with a one-cycle rxValid pulse, together
// with parity and framing status. The status flags hold their values until
// the next rxValid pulse.
//
// Optional feature macro: UART_RX_PARITY_CHECK_EN
//     defined   : parityErr reports a mismatch between the received parity
//                 bit and the XOR of the received data bits.
//     undefined : the parity bit is still timed and skipped, so frame timing
//                 stays compatible with the transmitter. The compare logic is
//                 removed and parityErr is tied to 0.
//
// Parameters:
//     FRAMEWIDTH   : number of data bits per frame.
//     CLKS_PER_BIT : clk cycles per bit period. Must be an even number >= 4.
//     N            : width of the bit-period counter.
//
// Ports:
//     clk       in   system clock
//     rst       in   asynchronous, active-low reset
//     rx        in   serial line, asynchronous to clk, idles high
//     rxData    out  last received word
//     rxValid   out  one-cycle pulse: rxData and the error flags were updated
//     parityErr out  parity mismatch on the last word
//     frameErr  out  stop bit sampled 0 on the last word
//     busy      out  high while the FSM is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int FRAMEWIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int N            = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [FRAMEWIDTH-1:0] rxData,
    output logic                  rxValid,
    output logic                  parityErr,
    output logic                  frameErr,
    output logic                  busy
);

    localparam int BW = $clog2(FRAMEWIDTH + 1);

    // Terminal counts. START waits half a bit period so that every later
    // sample, taken one full bit period apart, lands in the middle of a bit.
    localparam logic [N-1:0]  HALF_LAST = N'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N-1:0]  BIT_LAST  = N'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(FRAMEWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } stateT;

    stateT                 state;
    logic                  rxMeta;
    logic                  rxs;
    logic [N-1:0]          cnt;
    logic [BW-1:0]         bitCnt;
    logic [FRAMEWIDTH-1:0] shift;
`ifdef UART_RX_PARITY_CHECK_EN
    logic                  pbit;
`endif

    // Two-flop synchroniser for the asynchronous rx pin. Both flops reset
    // to 1 (line idle) so that leaving reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxs    <= rxMeta;
        end
    end

    // Receive FSM. Every decision uses the synchronised rxs. The bit-period
    // counter restarts on every state change and after every sample, and a
    // sample is taken on the cycle the counter reaches its terminal value.
    // All outputs are registered here; rxValid defaults low so it can only
    // ever be a single-cycle pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bitCnt    <= '0;
            shift     <= '0;
            rxData    <= '0;
            rxValid   <= 1'b0;
            frameErr  <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
            pbit      <= 1'b0;
            parityErr <= 1'b0;
`endif
        end else begin
            rxValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                // A start bit that is no longer low at mid-bit was a glitch;
                // drop back to IDLE without touching any output but busy.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= DATA;
                            bitCnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Shifting in at the MSB end means the first (LSB) data bit
                // ends up at bit 0 once all FRAMEWIDTH bits are in.
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        shift  <= {rxs, shift[FRAMEWIDTH-1:1]};
                        bitCnt <= bitCnt + 1'b1;
                        if (bitCnt == DATA_LAST) begin
                            state <= PARITY;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Without the parity check the bit period is still spent
                // here so the stop bit is sampled at the right time.
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
`ifdef UART_RX_PARITY_CHECK_EN
                        pbit  <= rxs;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // A low stop bit means the line may be held low (break); the
                // BREAK state waits it out instead of seeing a new start bit.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        rxData    <= shift;
                        rxValid   <= 1'b1;
                        frameErr  <= ~rxs;
`ifdef UART_RX_PARITY_CHECK_EN
                        parityErr <= (^shift) != pbit;
`endif
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_CHECK_EN
    // Parity checking compiled out: the flag is permanently clear.
    assign parityErr = 1'b0;
`endif

endmodule
